spi_register_responder: RTL and testbench

//  SPI mode-0 target that answers the ADXL362-style register protocol issued by our SPI controller:

---
 rtl/spi_resp_pkg.sv | 18 +
 rtl/spi_input_sync.sv | 87 ++++++++
 rtl/spi_register_responder.sv | 211 +++++++++++++++++++++
 tb/tb_spi_register_responder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_resp_pkg.sv
// Shared types and constants for the SPI register responder.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package spi_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    IGNORE
  } resp_state_t;

  localparam logic [7:0] CMD_WRITE  = 8'h0A;
  localparam logic [7:0] CMD_READ   = 8'h0B;
  localparam logic [7:0] DEVID_ADDR = 8'h00;

endpackage

// File: rtl/spi_input_sync.sv
// Two-flop synchronizers for SCLK/MOSI/CS plus registered edge pulses.
// Latency: edge pulses appear 3 core clocks after the pin edge; mosi_bit is aligned with sclk_rise.
// Backpressure: none; CS edges are suppressed until CS has been seen high after reset.
module spi_input_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk_pin,
  input  logic mosi_pin,
  input  logic cs_n_pin,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic mosi_bit,
  output logic cs_fall,
  output logic cs_rise,
  output logic cs_active
);

  logic       sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic       cs_meta_q, cs_sync_q, cs_prev_q;
  logic       mosi_meta_q, mosi_sync_q, mosi_q;
  logic [1:0] warm_q, warm_d;
  logic       armed_q, armed_d;
  logic       sclk_rise_q, sclk_rise_d;
  logic       sclk_fall_q, sclk_fall_d;
  logic       cs_fall_q, cs_fall_d;
  logic       cs_rise_q, cs_rise_d;
  logic       cs_active_q, cs_active_d;

  // Edge detection; CS only arms once the synchronizer holds real pin data showing CS high,
  // so a frame already in progress when reset releases is ignored.
  always_comb begin
    warm_d      = {warm_q[0], 1'b1};
    armed_d     = armed_q | (warm_q[1] & cs_sync_q);
    sclk_rise_d = sclk_sync_q & ~sclk_prev_q;
    sclk_fall_d = ~sclk_sync_q & sclk_prev_q;
    cs_fall_d   = armed_q & cs_prev_q & ~cs_sync_q;
    cs_rise_d   = armed_q & ~cs_prev_q & cs_sync_q;
    cs_active_d = armed_q & ~cs_sync_q;
  end

  // Synchronizer chains and pulse registers; CS resets to its idle (high) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_prev_q   <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      mosi_q      <= 1'b0;
      warm_q      <= 2'b00;
      armed_q     <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_active_q <= 1'b0;
    end else begin
      sclk_meta_q <= sclk_pin;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      cs_meta_q   <= cs_n_pin;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      mosi_meta_q <= mosi_pin;
      mosi_sync_q <= mosi_meta_q;
      mosi_q      <= mosi_sync_q;
      warm_q      <= warm_d;
      armed_q     <= armed_d;
      sclk_rise_q <= sclk_rise_d;
      sclk_fall_q <= sclk_fall_d;
      cs_fall_q   <= cs_fall_d;
      cs_rise_q   <= cs_rise_d;
      cs_active_q <= cs_active_d;
    end
  end

  assign sclk_rise = sclk_rise_q;
  assign sclk_fall = sclk_fall_q;
  assign mosi_bit  = mosi_q;
  assign cs_fall   = cs_fall_q;
  assign cs_rise   = cs_rise_q;
  assign cs_active = cs_active_q;

endmodule

// File: rtl/spi_register_responder.sv
// SPI mode-0 register target (0x0A write / 0x0B read, then address, then data) with write reporting.
// Latency: wr_strobe one core clock after the synchronized 8th SCLK rise of a data byte.
// Backpressure: none; SCLK up to 5 MHz. Define SPI_RESP_BURST_EN for auto-incrementing bursts.
module spi_register_responder #(
  parameter int         NUM_REGS    = 64,
  parameter logic [7:0] DEVID_VALUE = 8'hAD
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       SPI_SCLK,
  input  logic       SPI_MOSI,
  input  logic       SPI_CS,
  output logic       SPI_MISO,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       frame_err
);

  import spi_resp_pkg::*;

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic sclk_rise, sclk_fall, mosi_bit, cs_fall, cs_rise, cs_active;

  spi_input_sync u_sync (
    .clk       (CLK100MHZ),
    .rst_n     (CPU_RESETN),
    .sclk_pin  (SPI_SCLK),
    .mosi_pin  (SPI_MOSI),
    .cs_n_pin  (SPI_CS),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .mosi_bit  (mosi_bit),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .cs_active (cs_active)
  );

  resp_state_t state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic        is_read_q, is_read_d;
  logic [7:0]  addr_ptr_q, addr_ptr_d;
  logic [7:0]  miso_sh_q, miso_sh_d;
  logic        miso_en_q, miso_en_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        frame_err_q, frame_err_d;

  logic [7:0]    reg_file_q [NUM_REGS];
  logic          reg_we;
  logic [AW-1:0] reg_wa;
  logic [7:0]    byte_in;
  logic [7:0]    rd_addr_byte;
  logic          addr_writable;

  // Address 0 is the fixed device ID; anything past the implemented range reads as zero.
  function automatic logic [7:0] rd_byte(input logic [7:0] a);
    if (a == DEVID_ADDR) begin
      return DEVID_VALUE;
    end else if (32'(a) < NUM_REGS) begin
      return reg_file_q[a[AW-1:0]];
    end else begin
      return 8'h00;
    end
  endfunction

  assign byte_in       = {shift_q, mosi_bit};
  assign rd_addr_byte  = rd_byte(byte_in);
  assign addr_writable = (addr_ptr_q != DEVID_ADDR) && (32'(addr_ptr_q) < NUM_REGS);

`ifdef SPI_RESP_BURST_EN
  logic [7:0] addr_next;
  logic [7:0] rd_next_byte;
  assign addr_next    = addr_ptr_q + 8'd1;
  assign rd_next_byte = rd_byte(addr_next);
`endif

  // Frame FSM: byte assembly, command decode, register commit and MISO shifter control.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    is_read_d   = is_read_q;
    addr_ptr_d  = addr_ptr_q;
    miso_sh_d   = miso_sh_q;
    miso_en_d   = miso_en_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    reg_we      = 1'b0;
    reg_wa      = addr_ptr_q[AW-1:0];

    if (cs_rise) begin
      // CS deassertion wins over any coincident SCLK edge; a partial byte is dropped.
      state_d     = IDLE;
      bit_cnt_d   = 3'd0;
      miso_en_d   = 1'b0;
      miso_sh_d   = 8'h00;
      frame_err_d = (bit_cnt_q != 3'd0);
    end else if (state_q == IDLE) begin
      if (cs_fall) begin
        state_d   = CMD;
        bit_cnt_d = 3'd0;
        shift_d   = 7'd0;
      end
    end else begin
      // No shift on the fall that follows a byte boundary: the freshly loaded MSB must
      // stay on the pin for the first rise of the next byte.
      if (sclk_fall && (bit_cnt_q != 3'd0)) begin
        miso_sh_d = {miso_sh_q[6:0], 1'b0};
      end
      if (sclk_rise) begin
        shift_d   = byte_in[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            CMD: begin
              if ((byte_in == CMD_WRITE) || (byte_in == CMD_READ)) begin
                state_d   = ADDR;
                is_read_d = (byte_in == CMD_READ);
              end else begin
                state_d = IGNORE;
              end
            end
            ADDR: begin
              state_d    = DATA;
              addr_ptr_d = byte_in;
              if (is_read_q) begin
                miso_sh_d = rd_addr_byte;
                miso_en_d = 1'b1;
              end
            end
            DATA: begin
              if (!is_read_q) begin
                reg_we      = addr_writable;
                wr_strobe_d = 1'b1;
                wr_addr_d   = addr_ptr_q;
                wr_data_d   = byte_in;
              end
`ifdef SPI_RESP_BURST_EN
              addr_ptr_d = addr_next;
              if (is_read_q) begin
                miso_sh_d = rd_next_byte;
              end
`else
              state_d   = IGNORE;
              miso_en_d = 1'b0;
`endif
            end
            default: begin
              miso_en_d = 1'b0;
            end
          endcase
        end
      end
    end
  end

  // Single state register for the FSM and its registered outputs.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      is_read_q   <= 1'b0;
      addr_ptr_q  <= 8'h00;
      miso_sh_q   <= 8'h00;
      miso_en_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      is_read_q   <= is_read_d;
      addr_ptr_q  <= addr_ptr_d;
      miso_sh_q   <= miso_sh_d;
      miso_en_q   <= miso_en_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Register file, cleared by reset; slot 0 is never written (device ID is a constant).
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_file_q[i] <= 8'h00;
      end
    end else if (reg_we) begin
      reg_file_q[reg_wa] <= byte_in;
    end
  end

  assign SPI_MISO  = miso_sh_q[7] & miso_en_q & ~SPI_CS;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = cs_active;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_register_responder.sv
// Directed bench for spi_register_responder: reads, writes, bad command, partial frame,
// burst (SPI_RESP_BURST_EN) or single-byte behaviour, and reset in the middle of a read.
module tb_spi_register_responder;

  localparam int HALF = 120;  // SCLK half period, about 4.2 MHz

  logic       CLK100MHZ = 1'b0;
  logic       CPU_RESETN;
  logic       SPI_SCLK;
  logic       SPI_MOSI;
  logic       SPI_CS;
  logic       SPI_MISO;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       frame_err;

  spi_register_responder #(
    .NUM_REGS    (64),
    .DEVID_VALUE (8'hAD)
  ) dut (
    .CLK100MHZ  (CLK100MHZ),
    .CPU_RESETN (CPU_RESETN),
    .SPI_SCLK   (SPI_SCLK),
    .SPI_MOSI   (SPI_MOSI),
    .SPI_CS     (SPI_CS),
    .SPI_MISO   (SPI_MISO),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int         n_cmp = 0;
  int         n_err = 0;
  int         wr_cnt = 0;
  int         fe_cnt = 0;
  logic [7:0] wr_addr_log [$];
  logic [7:0] wr_data_log [$];

  // Log every write report and framing error, sampled away from the active edge.
  always @(negedge CLK100MHZ) begin
    if (wr_strobe) begin
      wr_cnt++;
      wr_addr_log.push_back(wr_addr);
      wr_data_log.push_back(wr_data);
    end
    if (frame_err) fe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      SPI_MOSI = tx[i];
      #(HALF);
      rx[i] = SPI_MISO;
      SPI_SCLK = 1'b1;
      #(HALF);
      SPI_SCLK = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    xfer_bits(tx, 8, rx);
  endtask

  task automatic frame_begin();
    SPI_CS = 1'b0;
    #(HALF);
  endtask

  task automatic frame_end();
    #(HALF);
    SPI_CS = 1'b1;
    SPI_MOSI = 1'b0;
    #400;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] rx;
    frame_begin();
    xfer(8'h0A, rx);
    xfer(a, rx);
    xfer(d, rx);
    frame_end();
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [7:0] d);
    logic [7:0] rx;
    frame_begin();
    xfer(8'h0B, rx);
    xfer(a, rx);
    xfer(8'h00, d);
    frame_end();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] rx, rx2, acc;
    int         w0, f0;

    CPU_RESETN = 1'b0;
    SPI_SCLK   = 1'b0;
    SPI_MOSI   = 1'b0;
    SPI_CS     = 1'b1;
    #100;
    chk("rst_miso", 32'(SPI_MISO), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_wr_strobe", 32'(wr_strobe), 32'h0);
    chk("rst_wr_addr", 32'(wr_addr), 32'h0);
    chk("rst_wr_data", 32'(wr_data), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    CPU_RESETN = 1'b1;
    #100;
    @(posedge CLK100MHZ);
    #2;

    // 1. Device ID read
    w0 = wr_cnt;
    frame_begin();
    chk("s1_busy_in_frame", 32'(busy), 32'h1);
    xfer(8'h0B, rx);
    xfer(8'h00, rx);
    xfer(8'h00, rx);
    frame_end();
    chk("s1_devid", 32'(rx), 32'hAD);
    chk("s1_no_strobe", 32'(wr_cnt - w0), 32'h0);
    chk("s1_busy_after", 32'(busy), 32'h0);

    // 2. Write then read back
    w0 = wr_cnt;
    write_reg(8'h1F, 8'h5A);
    chk("s2_strobe_cnt", 32'(wr_cnt - w0), 32'h1);
    if (wr_cnt > w0) begin
      chk("s2_wr_addr", 32'(wr_addr_log[w0]), 32'h1F);
      chk("s2_wr_data", 32'(wr_data_log[w0]), 32'h5A);
    end
    read_reg(8'h1F, rx);
    chk("s2_readback", 32'(rx), 32'h5A);

    // 3. Unknown command: frame ignored
    w0 = wr_cnt;
    frame_begin();
    xfer(8'h07, rx);
    acc = rx;
    xfer(8'h10, rx);
    acc |= rx;
    xfer(8'hFF, rx);
    acc |= rx;
    frame_end();
    chk("s3_miso_zero", 32'(acc), 32'h0);
    chk("s3_no_strobe", 32'(wr_cnt - w0), 32'h0);
    read_reg(8'h10, rx);
    chk("s3_reg10", 32'(rx), 32'h0);

    // 4. Partial data byte
    w0 = wr_cnt;
    f0 = fe_cnt;
    frame_begin();
    xfer(8'h0A, rx);
    xfer(8'h20, rx);
    xfer_bits(8'hC3, 5, rx);
    frame_end();
    chk("s4_frame_err", 32'(fe_cnt - f0), 32'h1);
    chk("s4_no_strobe", 32'(wr_cnt - w0), 32'h0);
    read_reg(8'h20, rx);
    chk("s4_reg20", 32'(rx), 32'h0);

    // Write to the read-only device ID is reported but not committed
    w0 = wr_cnt;
    write_reg(8'h00, 8'h55);
    chk("ro_strobe_cnt", 32'(wr_cnt - w0), 32'h1);
    if (wr_cnt > w0) chk("ro_wr_addr", 32'(wr_addr_log[w0]), 32'h00);
    read_reg(8'h00, rx);
    chk("ro_devid_kept", 32'(rx), 32'hAD);

    // 5. Multi-byte write crossing the end of the register file
    w0 = wr_cnt;
    frame_begin();
    xfer(8'h0A, rx);
    xfer(8'h3E, rx);
    xfer(8'h11, rx);
    xfer(8'h22, rx);
    xfer(8'h33, rx);
    frame_end();
    frame_begin();
    xfer(8'h0B, rx);
    xfer(8'h3E, rx);
    xfer(8'h00, rx);
    xfer(8'h00, rx2);
    frame_end();
    chk("s5_read0", 32'(rx), 32'h11);
`ifdef SPI_RESP_BURST_EN
    chk("s5_strobe_cnt", 32'(wr_cnt - w0), 32'h3);
    if (wr_cnt >= w0 + 3) begin
      chk("s5_wa0", 32'(wr_addr_log[w0]), 32'h3E);
      chk("s5_wd0", 32'(wr_data_log[w0]), 32'h11);
      chk("s5_wa1", 32'(wr_addr_log[w0+1]), 32'h3F);
      chk("s5_wd1", 32'(wr_data_log[w0+1]), 32'h22);
      chk("s5_wa2", 32'(wr_addr_log[w0+2]), 32'h40);
      chk("s5_wd2", 32'(wr_data_log[w0+2]), 32'h33);
    end
    chk("s5_read1", 32'(rx2), 32'h22);
    read_reg(8'h3F, rx);
    chk("s5_reg3f", 32'(rx), 32'h22);
`else
    chk("s5_strobe_cnt", 32'(wr_cnt - w0), 32'h1);
    if (wr_cnt > w0) begin
      chk("s5_wa0", 32'(wr_addr_log[w0]), 32'h3E);
      chk("s5_wd0", 32'(wr_data_log[w0]), 32'h11);
    end
    chk("s5_read1_ignored", 32'(rx2), 32'h00);
    read_reg(8'h3F, rx);
    chk("s5_reg3f", 32'(rx), 32'h00);
`endif
    read_reg(8'h40, rx);
    chk("s5_reg40_oob", 32'(rx), 32'h00);
    chk("frame_err_total", 32'(fe_cnt), 32'h1);

    // 6. Reset in the middle of reading 0x1F (0x5A); data bit 3 is a 1
    frame_begin();
    xfer(8'h0B, rx);
    xfer(8'h1F, rx);
    xfer_bits(8'h00, 4, rx);
    chk("s6_bits_before", 32'(rx), 32'h50);
    #60;
    chk("s6_miso_bit3", 32'(SPI_MISO), 32'h1);
    CPU_RESETN = 1'b0;
    #1;
    chk("s6_miso_in_reset", 32'(SPI_MISO), 32'h0);
    chk("s6_busy_in_reset", 32'(busy), 32'h0);
    #59;
    CPU_RESETN = 1'b1;
    w0 = wr_cnt;
    f0 = fe_cnt;
    xfer_bits(8'h00, 4, rx);
    acc = rx;
    xfer(8'h0A, rx);
    acc |= rx;
    xfer(8'h1F, rx);
    acc |= rx;
    xfer(8'h77, rx);
    acc |= rx;
    frame_end();
    chk("s6_tail_miso", 32'(acc), 32'h0);
    chk("s6_tail_no_strobe", 32'(wr_cnt - w0), 32'h0);
    chk("s6_tail_no_ferr", 32'(fe_cnt - f0), 32'h0);
    read_reg(8'h1F, rx);
    chk("s6_reg1f_cleared", 32'(rx), 32'h00);
    read_reg(8'h3E, rx);
    chk("s6_reg3e_cleared", 32'(rx), 32'h00);
    read_reg(8'h00, rx);
    chk("s6_devid_after", 32'(rx), 32'hAD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
